// File: rtl/update_tick_gen.sv
// -----------------------------------------------------------------------------
// update_tick_gen
//
// Programmable update-tick generator. A counter runs from 0 to period_reg-1
// and a registered tick Z is issued in the cycle after the terminal count.
// Periodic mode (Mode=0) runs forever; one-shot mode (Mode=1) is armed by
// Start and drops back to IDLE after a single tick. The period register can be
// reloaded at any time with Load; a zero period is rejected.
//
// Optional feature macro: UPDATE_TICK_GEN_HOLD_EN
//   defined   : Z is held high until the cycle after Ack; a tick that arrives
//               while Z is still unacknowledged sets the sticky Overrun flag.
//   undefined : Z is a single-cycle pulse, Ack is ignored, Overrun is 0.
//
// Ports
//   CLK      in   clock, rising edge
//   Rst      in   synchronous active-high reset
//   En       in   count enable (0 = pause)
//   Mode     in   0 = periodic, 1 = one-shot
//   Start    in   one-shot arm / retrigger strobe
//   Load     in   strobe: load PeriodIn into the period register
//   PeriodIn in   [WIDTH] new period, in cycles
//   Ack      in   tick acknowledge (hold build only)
//   Z        out  registered tick
//   Busy     out  high while in RUN
//   Count    out  [WIDTH] current counter value
//   Overrun  out  sticky missed-tick flag
// -----------------------------------------------------------------------------
module update_tick_gen #(
  parameter int          WIDTH  = 24,
  parameter int unsigned PERIOD = 12500000
) (
  input  logic             CLK,
  input  logic             Rst,
  input  logic             En,
  input  logic             Mode,
  input  logic             Start,
  input  logic             Load,
  input  logic [WIDTH-1:0] PeriodIn,
  input  logic             Ack,
  output logic             Z,
  output logic             Busy,
  output logic [WIDTH-1:0] Count,
  output logic             Overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] period_rst = WIDTH'(PERIOD);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             z_q, z_d;
  logic             load_ok;
  logic             terminal;
  logic             tick;

  assign load_ok  = Load && (PeriodIn != '0);
  assign terminal = (state_q == RUN) && En && (count_q == period_q - WIDTH'(1));

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    tick     = 1'b0;

    if (load_ok) begin
      // Load beats everything else, including a coincident terminal count.
      period_d = PeriodIn;
      count_d  = '0;
    end else if (En) begin
      unique case (state_q)
        IDLE: begin
          if (!Mode || Start) state_d = RUN;
        end
        RUN: begin
          if (Mode && Start) begin
            count_d = '0;                 // one-shot retrigger, no tick
          end else if (terminal) begin
            count_d = '0;
            tick    = 1'b1;
            state_d = Mode ? IDLE : RUN;  // Mode is sampled here
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef UPDATE_TICK_GEN_HOLD_EN
  logic ovr_q, ovr_d;

  always_comb begin
    z_d   = z_q;
    ovr_d = ovr_q;
    if (tick) begin
      // A same-cycle Ack consumes the old tick, so only an unacknowledged
      // pending tick counts as missed.
      if (z_q && !Ack) ovr_d = 1'b1;
      z_d = 1'b1;
    end else if (Ack) begin
      z_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Rst) ovr_q <= 1'b0;
    else     ovr_q <= ovr_d;
  end

  assign Overrun = ovr_q;
`else
  logic unused_ack;
  assign unused_ack = Ack;
  assign z_d        = tick;
  assign Overrun    = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational block.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= period_rst;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      z_q      <= z_d;
    end
  end

  assign Z     = z_q;
  assign Busy  = (state_q == RUN);
  assign Count = count_q;

endmodule

// File: tb/tb_update_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_update_tick_gen
//
// Self-checking bench for update_tick_gen (WIDTH=8, PERIOD=5). A hand-written
// vector table covers the main directed behaviour, short sequences cover the
// multi-cycle corners, and a randomized phase is compared cycle by cycle with
// a behavioural reference model. Builds with or without UPDATE_TICK_GEN_HOLD_EN.
// -----------------------------------------------------------------------------
module tb_update_tick_gen;

  localparam int WIDTH  = 8;
  localparam int PERIOD = 5;

  logic             CLK = 1'b0;
  logic             Rst, En, Mode, Start, Load, Ack;
  logic [WIDTH-1:0] PeriodIn;
  logic             Z, Busy, Overrun;
  logic [WIDTH-1:0] Count;

  int checks = 0;
  int errors = 0;

  update_tick_gen #(.WIDTH(WIDTH), .PERIOD(PERIOD)) dut (
    .CLK(CLK), .Rst(Rst), .En(En), .Mode(Mode), .Start(Start), .Load(Load),
    .PeriodIn(PeriodIn), .Ack(Ack), .Z(Z), .Busy(Busy), .Count(Count),
    .Overrun(Overrun)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  bit m_run;
  int m_cnt, m_per;
  bit m_z, m_ovr;

  task automatic model_step();
    bit fire;
    fire = 1'b0;
    if (Rst) begin
      m_run = 0; m_cnt = 0; m_per = PERIOD; m_z = 0; m_ovr = 0;
      return;
    end
    if (Load && PeriodIn != 0) begin
      m_per = int'(PeriodIn);
      m_cnt = 0;
    end else if (En) begin
      if (!m_run) begin
        if (!Mode || Start) m_run = 1;
      end else if (Mode && Start) begin
        m_cnt = 0;
      end else if (m_cnt + 1 == m_per) begin
        fire  = 1;
        m_cnt = 0;
        if (Mode) m_run = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
`ifdef UPDATE_TICK_GEN_HOLD_EN
    if (fire) begin
      if (m_z && !Ack) m_ovr = 1;
      m_z = 1;
    end else if (Ack) begin
      m_z = 0;
    end
`else
    m_z = fire;
`endif
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the pre-edge inputs, then compare after
  // the edge.
  task automatic do_cycle();
    model_step();
    @(posedge CLK);
    #1;
    check("model_count",   32'(Count),   32'(m_cnt));
    check("model_z",       32'(Z),       32'(m_z));
    check("model_busy",    32'(Busy),    32'(m_run));
    check("model_overrun", 32'(Overrun), 32'(m_ovr));
  endtask

  task automatic set_in(input logic rst, input logic en, input logic mode,
                        input logic start, input logic load,
                        input logic [WIDTH-1:0] pin, input logic ack);
    Rst = rst; En = en; Mode = mode; Start = start; Load = load;
    PeriodIn = pin; Ack = ack;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             rst, en, mode, start, load;
    logic [WIDTH-1:0] pin;
    logic             ez, ebusy;
    logic [WIDTH-1:0] ecnt;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(input logic rst, en, mode, start, load,
                              input logic [WIDTH-1:0] pin,
                              input logic ez, ebusy,
                              input logic [WIDTH-1:0] ecnt);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = mode; v.start = start; v.load = load;
    v.pin = pin; v.ez = ez; v.ebusy = ebusy; v.ecnt = ecnt;
    return v;
  endfunction

  initial begin
    //            rst en md st ld pin   z  busy cnt
    vecs[0]  = mk(1, 0, 0, 0, 0, 0,    0, 0, 0); // reset
    vecs[1]  = mk(0, 1, 0, 0, 0, 0,    0, 1, 0); // IDLE exit
    vecs[2]  = mk(0, 1, 0, 0, 0, 0,    0, 1, 1);
    vecs[3]  = mk(0, 1, 0, 0, 0, 0,    0, 1, 2);
    vecs[4]  = mk(0, 1, 0, 0, 0, 0,    0, 1, 3);
    vecs[5]  = mk(0, 1, 0, 0, 0, 0,    0, 1, 4);
    vecs[6]  = mk(0, 1, 0, 0, 0, 0,    1, 1, 0); // first tick
    vecs[7]  = mk(0, 1, 0, 0, 0, 0,    0, 1, 1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0,    0, 1, 1); // pause
    vecs[9]  = mk(0, 1, 0, 0, 0, 0,    0, 1, 2);
    vecs[10] = mk(0, 1, 0, 0, 1, 0,    0, 1, 3); // Load 0 ignored
    vecs[11] = mk(0, 1, 0, 0, 0, 0,    0, 1, 4);
    vecs[12] = mk(0, 1, 0, 0, 1, 3,    0, 1, 0); // Load beats terminal
    vecs[13] = mk(0, 1, 0, 0, 0, 0,    0, 1, 1);
    vecs[14] = mk(0, 1, 0, 0, 0, 0,    0, 1, 2);
    vecs[15] = mk(0, 1, 0, 0, 0, 0,    1, 1, 0); // period 3 tick
    vecs[16] = mk(0, 1, 0, 0, 0, 0,    0, 1, 1);
    vecs[17] = mk(1, 1, 0, 0, 0, 0,    0, 0, 0); // reset mid-period
    vecs[18] = mk(0, 1, 1, 0, 0, 0,    0, 0, 0); // one-shot, not armed
    vecs[19] = mk(0, 1, 1, 1, 0, 0,    0, 1, 0); // Start arms
    vecs[20] = mk(0, 1, 1, 0, 0, 0,    0, 1, 1);
    vecs[21] = mk(0, 1, 1, 1, 0, 0,    0, 1, 0); // retrigger
    vecs[22] = mk(0, 1, 1, 0, 0, 0,    0, 1, 1);
    vecs[23] = mk(0, 1, 1, 0, 0, 0,    0, 1, 2);
    vecs[24] = mk(0, 1, 1, 0, 0, 0,    0, 1, 3);
    vecs[25] = mk(0, 1, 1, 0, 0, 0,    0, 1, 4);
    vecs[26] = mk(0, 1, 1, 0, 0, 0,    1, 0, 0); // tick, back to IDLE
    vecs[27] = mk(0, 1, 1, 0, 0, 0,    0, 0, 0); // stays IDLE
  end

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 1);
    #2;

    // Ack is held high through the table so the tick looks like a pulse in
    // both builds.
    for (int i = 0; i < 28; i++) begin
      set_in(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].start,
             vecs[i].load, vecs[i].pin, 1'b1);
      do_cycle();
      check($sformatf("vec%0d_count", i), 32'(Count), 32'(vecs[i].ecnt));
      check($sformatf("vec%0d_z", i),     32'(Z),     32'(vecs[i].ez));
      check($sformatf("vec%0d_busy", i),  32'(Busy),  32'(vecs[i].ebusy));
      check($sformatf("vec%0d_ovr", i),   32'(Overrun), 32'(0));
    end

    // One-shot: no further tick without another Start.
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1, 1, 0, 0, 0, 1);
      do_cycle();
      check("oneshot_quiet_z", 32'(Z), 32'(0));
    end

    // Minimum period: Z on every enabled cycle.
    set_in(1, 0, 0, 0, 0, 0, 1); do_cycle();
    set_in(0, 1, 0, 0, 0, 0, 1); do_cycle();
    set_in(0, 1, 0, 0, 1, 1, 1); do_cycle();
    check("minper_load_z", 32'(Z), 32'(0));
    for (int i = 0; i < 6; i++) begin
      set_in(0, 1, 0, 0, 0, 0, 1);
      do_cycle();
      check("minper_z", 32'(Z), 32'(1));
      check("minper_count", 32'(Count), 32'(0));
    end

    // Reset at Count=3, then the reset period (5) must be back.
    set_in(1, 0, 0, 0, 0, 0, 1); do_cycle();
    set_in(0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) do_cycle();
    check("rstmid_pre_count", 32'(Count), 32'(3));
    set_in(1, 1, 0, 0, 0, 0, 1); do_cycle();
    check("rstmid_count", 32'(Count), 32'(0));
    check("rstmid_z", 32'(Z), 32'(0));
    check("rstmid_busy", 32'(Busy), 32'(0));
    set_in(0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      do_cycle();
      check("rstmid_no_tick", 32'(Z), 32'(0));
    end
    do_cycle();
    check("rstmid_tick_period5", 32'(Z), 32'(1));

`ifdef UPDATE_TICK_GEN_HOLD_EN
    // Hold: Ack withheld for 7 cycles after the first tick.
    set_in(1, 0, 0, 0, 0, 0, 0); do_cycle();
    set_in(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) do_cycle();
    check("hold_first_z", 32'(Z), 32'(1));
    check("hold_first_ovr", 32'(Overrun), 32'(0));
    for (int i = 0; i < 5; i++) do_cycle();
    check("hold_second_z", 32'(Z), 32'(1));
    check("hold_second_ovr", 32'(Overrun), 32'(1));
    do_cycle();
    set_in(0, 1, 0, 0, 0, 0, 1); do_cycle();
    check("hold_ack_z", 32'(Z), 32'(0));
    check("hold_ack_ovr", 32'(Overrun), 32'(1));
    set_in(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) do_cycle();
    check("hold_sticky_ovr", 32'(Overrun), 32'(1));
    set_in(1, 1, 0, 0, 0, 0, 0); do_cycle();
    check("hold_rst_ovr", 32'(Overrun), 32'(0));
    // Ack coinciding with a terminal: Z stays, no overrun.
    set_in(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) do_cycle();
    set_in(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_cycle();
    set_in(0, 1, 0, 0, 0, 0, 1); do_cycle();
    check("hold_ack_term_z", 32'(Z), 32'(1));
    check("hold_ack_term_ovr", 32'(Overrun), 32'(0));
`else
    // Pulse build: Ack has no effect on Z.
    set_in(1, 0, 0, 0, 0, 0, 0); do_cycle();
    set_in(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) do_cycle();
    check("pulse_noack_z", 32'(Z), 32'(1));
    do_cycle();
    check("pulse_noack_drop", 32'(Z), 32'(0));
`endif

    // Randomized phase against the model.
    set_in(1, 0, 0, 0, 0, 0, 0); do_cycle();
    for (int i = 0; i < 1500; i++) begin
      Rst      = ($urandom_range(0, 79) == 0);
      En       = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) Mode = ~Mode;
      Start    = ($urandom_range(0, 9) == 0);
      Load     = ($urandom_range(0, 19) == 0);
      PeriodIn = WIDTH'($urandom_range(0, 7));
      Ack      = ($urandom_range(0, 2) == 0);
      do_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
